// File: rtl/vai_pkg.sv
// Shared VAI definitions: CCI-P Tx request structs, sub-AFU id (vmid) placement
// in mdata, and the default per-sub-AFU address window.
package vai_pkg;

    localparam int VAI_NUM_SUB_AFUS = 8;
    localparam int VAI_VMID_WIDTH   = 3;
    localparam int VAI_VMID_MSB     = 15;
    localparam int VAI_VMID_LSB     = 16 - VAI_VMID_WIDTH;
    localparam int VAI_WINDOW_LOG2  = 26;

    typedef logic [41:0]                 t_ccip_clAddr;
    typedef logic [15:0]                 t_ccip_mdata;
    typedef logic [511:0]                t_ccip_clData;
    typedef logic [VAI_VMID_WIDTH-1:0]   t_vmid;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic [1:0]   rsvd1;
        logic [1:0]   cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]   rsvd2;
        logic [1:0]   vc_sel;
        logic         sop;
        logic         rsvd1;
        logic [1:0]   cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    function automatic t_vmid vmid_of(t_ccip_mdata m);
        return m[VAI_VMID_MSB:VAI_VMID_LSB];
    endfunction

endpackage

// File: rtl/vai_tx_addr_translator_lane.sv
// One Tx channel of the translator: T1 capture + window/reset check, T2 offset
// add and suppress. HAS_SOP enables the per-burst drop latch (c1 only).
module vai_xlate_lane #(
    parameter int PAYLOAD_W    = 64,
    parameter int NUM_SUB_AFUS = 8,
    parameter int VMID_WIDTH   = 3,
    parameter int WINDOW_LOG2  = 26,
    parameter bit HAS_SOP      = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              valid_i,
    input  logic [PAYLOAD_W-1:0]              payload_i,
    input  logic [41:0]                       addr_i,
    input  logic [VMID_WIDTH-1:0]             vmid_i,
    input  logic                              sop_i,
    input  logic                              fence_i,
    input  logic [NUM_SUB_AFUS-1:0][41:0]     offset_i,
    input  logic [NUM_SUB_AFUS-1:0]           in_reset_i,
    output logic                              valid_o,
    output logic [PAYLOAD_W-1:0]              payload_o,
    output logic [41:0]                       addr_o,
    output logic                              drop_rst_o,
    output logic                              drop_oow_o,
    output logic [VMID_WIDTH-1:0]             vmid_o
);

    logic                  v1_q, hi1_q, first1_q, fence1_q;
    logic [PAYLOAD_W-1:0]  pl1_q;
    logic [41:0]           addr1_q;
    logic [VMID_WIDTH-1:0] vmid1_q;
    logic                  lat_rst_q, lat_oow_q;
    logic                  v2_q;
    logic [PAYLOAD_W-1:0]  pl2_q;
    logic [41:0]           addr2_q;

    logic        id_ok, rst_hit, new_oow, drop_rst, drop_oow;
    logic [41:0] off, addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            pl1_q    <= '0;
            addr1_q  <= '0;
            vmid1_q  <= '0;
            hi1_q    <= 1'b0;
            first1_q <= 1'b0;
            fence1_q <= 1'b0;
        end else begin
            v1_q     <= valid_i;
            pl1_q    <= payload_i;
            addr1_q  <= addr_i;
            vmid1_q  <= vmid_i;
            hi1_q    <= |addr_i[41:WINDOW_LOG2];
            // Fences never join a burst, so they always take a fresh decision.
            first1_q <= !HAS_SOP || sop_i || fence_i;
            fence1_q <= fence_i;
        end
    end

    always_comb begin
        id_ok    = (32'(vmid1_q) < NUM_SUB_AFUS);
        rst_hit  = id_ok && in_reset_i[vmid1_q];
        new_oow  = !rst_hit && (!id_ok || hi1_q) && !fence1_q;
        drop_rst = first1_q ? rst_hit : lat_rst_q;
        drop_oow = first1_q ? new_oow : lat_oow_q;
        off      = id_ok ? offset_i[vmid1_q] : '0;
        addr_d   = fence1_q ? addr1_q : addr1_q + off;
    end

    assign drop_rst_o = v1_q && drop_rst;
    assign drop_oow_o = v1_q && drop_oow;
    assign vmid_o     = vmid1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rst_q <= 1'b0;
            lat_oow_q <= 1'b0;
        end else if (v1_q && first1_q && !fence1_q) begin
            lat_rst_q <= rst_hit;
            lat_oow_q <= new_oow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            pl2_q   <= '0;
            addr2_q <= '0;
        end else begin
            v2_q    <= v1_q && !drop_rst && !drop_oow;
            pl2_q   <= pl1_q;
            addr2_q <= addr_d;
        end
    end

    assign valid_o   = v2_q;
    assign payload_o = pl2_q;
    assign addr_o    = addr2_q;

endmodule

// File: rtl/vai_tx_addr_translator.sv
// Per-sub-AFU Tx address translation and guard between the nested mux and vai_mgr.
// Two lanes (c0, c1) plus the shared violation flags and saturating drop counter.
module vai_tx_addr_translator
    import vai_pkg::*;
#(
    parameter int NUM_SUB_AFUS = VAI_NUM_SUB_AFUS,
    parameter int VMID_WIDTH   = VAI_VMID_WIDTH,
    parameter int WINDOW_LOG2  = VAI_WINDOW_LOG2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                           Clk,
    input  logic                           Resetb,
    input  t_if_ccip_c0_Tx                 in_c0,
    input  t_if_ccip_c1_Tx                 in_c1,
    input  logic [NUM_SUB_AFUS-1:0][63:0]  offset_array,
    input  logic [63:0]                    sub_afu_reset,
    output t_if_ccip_c0_Tx                 out_c0,
    output t_if_ccip_c1_Tx                 out_c1,
    output logic [NUM_SUB_AFUS-1:0]        violation_vec,
    output logic [CNT_WIDTH-1:0]           drop_count
);

    localparam int C0_W = $bits(t_if_ccip_c0_Tx);
    localparam int C1_W = $bits(t_if_ccip_c1_Tx);

    logic [NUM_SUB_AFUS-1:0][41:0] cl_off;
    logic [21:0]                   unused_off_hi;
    logic                          unused_rst_hi;

    always_comb begin
        unused_off_hi = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            cl_off[i]     = offset_array[i][41:0];
            unused_off_hi = unused_off_hi ^ offset_array[i][63:42];
        end
    end
    assign unused_rst_hi = ^sub_afu_reset[63:NUM_SUB_AFUS];

    logic [C0_W-1:0]       c0_pl;
    logic [C1_W-1:0]       c1_pl;
    logic [41:0]           c0_addr, c1_addr;
    logic                  c0_v, c1_v;
    logic                  c0_drst, c0_doow, c1_drst, c1_doow;
    logic [VMID_WIDTH-1:0] c0_vmid, c1_vmid;

    vai_xlate_lane #(
        .PAYLOAD_W(C0_W), .NUM_SUB_AFUS(NUM_SUB_AFUS), .VMID_WIDTH(VMID_WIDTH),
        .WINDOW_LOG2(WINDOW_LOG2), .HAS_SOP(1'b0)
    ) u_lane_c0 (
        .clk        (Clk),
        .rst_n      (Resetb),
        .valid_i    (in_c0.valid),
        .payload_i  (in_c0),
        .addr_i     (in_c0.hdr.address),
        .vmid_i     (in_c0.hdr.mdata[15 -: VMID_WIDTH]),
        .sop_i      (1'b0),
        .fence_i    (1'b0),
        .offset_i   (cl_off),
        .in_reset_i (sub_afu_reset[NUM_SUB_AFUS-1:0]),
        .valid_o    (c0_v),
        .payload_o  (c0_pl),
        .addr_o     (c0_addr),
        .drop_rst_o (c0_drst),
        .drop_oow_o (c0_doow),
        .vmid_o     (c0_vmid)
    );

    vai_xlate_lane #(
        .PAYLOAD_W(C1_W), .NUM_SUB_AFUS(NUM_SUB_AFUS), .VMID_WIDTH(VMID_WIDTH),
        .WINDOW_LOG2(WINDOW_LOG2), .HAS_SOP(1'b1)
    ) u_lane_c1 (
        .clk        (Clk),
        .rst_n      (Resetb),
        .valid_i    (in_c1.valid),
        .payload_i  (in_c1),
        .addr_i     (in_c1.hdr.address),
        .vmid_i     (in_c1.hdr.mdata[15 -: VMID_WIDTH]),
        .sop_i      (in_c1.hdr.sop),
        .fence_i    (in_c1.hdr.req_type == eREQ_WRFENCE),
        .offset_i   (cl_off),
        .in_reset_i (sub_afu_reset[NUM_SUB_AFUS-1:0]),
        .valid_o    (c1_v),
        .payload_o  (c1_pl),
        .addr_o     (c1_addr),
        .drop_rst_o (c1_drst),
        .drop_oow_o (c1_doow),
        .vmid_o     (c1_vmid)
    );

    always_comb begin
        out_c0             = t_if_ccip_c0_Tx'(c0_pl);
        out_c0.hdr.address = c0_addr;
        out_c0.valid       = c0_v;
        out_c1             = t_if_ccip_c1_Tx'(c1_pl);
        out_c1.hdr.address = c1_addr;
        out_c1.valid       = c1_v;
    end

    logic [NUM_SUB_AFUS-1:0] viol_d, viol_q;
    logic [CNT_WIDTH-1:0]    cnt_d, cnt_q;
    logic [1:0]              inc;
    logic [CNT_WIDTH:0]      sum;

    // Sub-AFU reset wins over a violation raised in the same cycle.
    always_comb begin
        viol_d = viol_q;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            if ((c0_doow && 32'(c0_vmid) == i) || (c1_doow && 32'(c1_vmid) == i))
                viol_d[i] = 1'b1;
            if (sub_afu_reset[i])
                viol_d[i] = 1'b0;
        end
        inc   = {1'b0, c0_drst | c0_doow} + {1'b0, c1_drst | c1_doow};
        sum   = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(inc);
        cnt_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            viol_q <= '0;
            cnt_q  <= '0;
        end else begin
            viol_q <= viol_d;
            cnt_q  <= cnt_d;
        end
    end

    assign violation_vec = viol_q;
    assign drop_count    = cnt_q;

endmodule
